// File: rtl/ibuf_tile_writer_if.sv
// rtl/ibuf_tile_writer_if.sv - stream-in and buffer-write bundle for the input tile writer
interface ibuf_tile_writer_if #(
    parameter int DW = 32
);
    logic          rvalid;
    logic          rready;
    logic          rlast;
    logic [DW-1:0] rdata;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [7:0]    wbank;
    logic [7:0]    wrow;
    logic [27:0]   wcol;

    modport master (
        output rvalid, rlast, rdata,
        input  rready, wen, wdata, wbank, wrow, wcol
    );

    modport slave (
        input  rvalid, rlast, rdata,
        output rready, wen, wdata, wbank, wrow, wcol
    );
endinterface

// File: rtl/ibuf_tile_writer.sv
// rtl/ibuf_tile_writer.sv - raster stream to POY-banked input buffer write-address generator
module ibuf_tile_writer #(
    parameter int DW     = 32,
    parameter int STRIDE = 1,
    parameter int POX    = 3,
    parameter int POY    = 3,
    parameter int KSIZE  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_load,
    input  logic [27:0]         cfg_cols,
    input  logic                tile_ack,
    output logic                tile_done,
    output logic                err_len,
    ibuf_tile_writer_if.slave   bus
);
    localparam int BUFW = (POX - 1) * STRIDE + KSIZE;
    localparam int LM   = (POY - 1) * STRIDE + KSIZE;

    localparam logic [27:0] BUFW_W   = 28'(BUFW);
    localparam logic [7:0]  LM_LAST  = 8'(LM - 1);
    localparam logic [7:0]  POY_LAST = 8'(POY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [27:0]   ncols;
    logic [27:0]   col;
    logic [7:0]    irow;
    // bank/brow track irow mod POY and irow / POY incrementally, so no divider is needed
    logic [7:0]    bank;
    logic [7:0]    brow;

    logic          wen_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    wbank_q;
    logic [7:0]    wrow_q;
    logic [27:0]   wcol_q;
    logic          tile_done_q;
    logic          err_len_q;

    logic [27:0]   ncols_in;
    logic          accept;
    logic          row_end;
    logic          last_word;

    // Out-of-range widths (0 or wider than the buffer) fall back to the full buffer width
    assign ncols_in  = (cfg_cols == 28'd0 || cfg_cols > BUFW_W) ? BUFW_W : cfg_cols;
    assign accept    = bus.rvalid && (state == ST_FILL);
    assign row_end   = (col == ncols - 28'd1);
    assign last_word = (irow == LM_LAST) && row_end;

    assign bus.rready = (state == ST_FILL);
    assign bus.wen    = wen_q;
    assign bus.wdata  = wdata_q;
    assign bus.wbank  = wbank_q;
    assign bus.wrow   = wrow_q;
    assign bus.wcol   = wcol_q;
    assign tile_done  = tile_done_q;
    assign err_len    = err_len_q;

    // Tile FSM, position counters and the registered write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ncols       <= BUFW_W;
            col         <= '0;
            irow        <= '0;
            bank        <= '0;
            brow        <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wbank_q     <= '0;
            wrow_q      <= '0;
            wcol_q      <= '0;
            tile_done_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else if (!data_load) begin
            // Session closed: drop everything except the held write-port values
            state       <= ST_IDLE;
            col         <= '0;
            irow        <= '0;
            bank        <= '0;
            brow        <= '0;
            wen_q       <= 1'b0;
            tile_done_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            wen_q       <= 1'b0;
            tile_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_FILL;
                    ncols <= ncols_in;
                    col   <= '0;
                    irow  <= '0;
                    bank  <= '0;
                    brow  <= '0;
                end
                ST_FILL: begin
                    if (accept) begin
                        wen_q   <= 1'b1;
                        wdata_q <= bus.rdata;
                        wbank_q <= bank;
                        wrow_q  <= brow;
                        wcol_q  <= col;
                        if (last_word || bus.rlast) begin
                            // Either end marker closes the tile; disagreement is a length error
                            state       <= ST_DONE;
                            tile_done_q <= 1'b1;
                            if (last_word != bus.rlast) begin
                                err_len_q <= 1'b1;
                            end
                        end else if (row_end) begin
                            col  <= '0;
                            irow <= irow + 8'd1;
                            if (bank == POY_LAST) begin
                                bank <= '0;
                                brow <= brow + 8'd1;
                            end else begin
                                bank <= bank + 8'd1;
                            end
                        end else begin
                            col <= col + 28'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (tile_ack) begin
                        state <= ST_FILL;
                        ncols <= ncols_in;
                        col   <= '0;
                        irow  <= '0;
                        bank  <= '0;
                        brow  <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ibuf_tile_writer.sv
// tb/tb_ibuf_tile_writer.sv - self-checking bench for ibuf_tile_writer
module tb_ibuf_tile_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_load;
    logic [27:0] cfg_cols;
    logic        tile_ack;
    logic        tile_done;
    logic        err_len;

    ibuf_tile_writer_if #(.DW(32)) bus ();

    ibuf_tile_writer #(
        .DW(32), .STRIDE(1), .POX(3), .POY(3), .KSIZE(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_load (data_load),
        .cfg_cols  (cfg_cols),
        .tile_ack  (tile_ack),
        .tile_done (tile_done),
        .err_len   (err_len),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] cfg;
        int          nwords;
        int          rlast_at;
        bit          gap;
        int          ncols;
        int          nwr;
        bit          err;
    } vec_t;

    vec_t vecs [7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int sc, input int idx);
        return 32'hD000_0000 | (32'(idx) << 8) | 32'(sc);
    endfunction

    task automatic cycle(input bit rv, input bit rl, input logic [31:0] d, output bit acc);
        bus.rvalid = rv;
        bus.rlast  = rl;
        bus.rdata  = d;
        acc = rv && (bus.rready === 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int sc, input vec_t v);
        int word;
        int cyc;
        int irow;
        bit acc;
        bit rv;
        bit done;
        word = 0;
        cyc  = 0;
        done = 1'b0;
        data_load = 1'b0;
        cycle(1'b0, 1'b0, 32'h0, acc);
        check("idle_err_len", err_len, 32'h0);
        cfg_cols  = v.cfg;
        data_load = 1'b1;
        while (!done && cyc < 200) begin
            rv = (word < v.nwords) && (!v.gap || (cyc % 2 == 0));
            cycle(rv, word == v.rlast_at, pat(sc, word), acc);
            cyc++;
            check("wen_follows_accept", bus.wen, acc);
            if (acc) begin
                irow = word / v.ncols;
                check("wbank", bus.wbank, irow % 3);
                check("wrow",  bus.wrow,  irow / 3);
                check("wcol",  bus.wcol,  word % v.ncols);
                check("wdata", bus.wdata, pat(sc, word));
                check("tile_done_on_write", tile_done, (word == v.nwr - 1));
                word++;
            end else begin
                check("tile_done_no_write", tile_done, 32'h0);
            end
            if (tile_done) begin
                done = 1'b1;
                check("rready_after_done", bus.rready, 32'h0);
            end
        end
        check("tile_finished", done, 32'h1);
        check("write_count", word, v.nwr);
        check("err_len", err_len, v.err);
    endtask

    initial begin
        bit acc;
        //          cfg     nwords rlast  gap  ncols nwr err
        vecs[0] = '{28'd5,  25,    24,    0,   5,    25, 0};
        vecs[1] = '{28'd5,  25,    24,    1,   5,    25, 0};
        vecs[2] = '{28'd3,  15,    14,    0,   3,    15, 0};
        vecs[3] = '{28'd0,  25,    24,    0,   5,    25, 0};
        vecs[4] = '{28'd9,  25,    24,    1,   5,    25, 0};
        vecs[5] = '{28'd5,  25,    7,     0,   5,    8,  1};
        vecs[6] = '{28'd5,  25,    -1,    0,   5,    25, 1};

        rst_n      = 1'b0;
        data_load  = 1'b0;
        cfg_cols   = 28'd5;
        tile_ack   = 1'b0;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rdata  = 32'h0;
        cycle(1'b0, 1'b0, 32'h0, acc);
        cycle(1'b0, 1'b0, 32'h0, acc);
        check("rst_rready",    bus.rready, 32'h0);
        check("rst_wen",       bus.wen,    32'h0);
        check("rst_wdata",     bus.wdata,  32'h0);
        check("rst_wbank",     bus.wbank,  32'h0);
        check("rst_wrow",      bus.wrow,   32'h0);
        check("rst_wcol",      bus.wcol,   32'h0);
        check("rst_tile_done", tile_done,  32'h0);
        check("rst_err_len",   err_len,    32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Errored tile, acknowledged three cycles later: next tile restarts at 0/0/0, err_len kept
        run_vec(9, vecs[5]);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, acc);
            check("done_holds_rready", bus.rready, 32'h0);
        end
        tile_ack = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, acc);
        check("ack_rready_latency", bus.rready, 32'h1);
        tile_ack = 1'b0;
        cycle(1'b1, 1'b0, pat(11, 0), acc);
        check("ack_next_wen",   bus.wen,   32'h1);
        check("ack_next_wbank", bus.wbank, 32'h0);
        check("ack_next_wrow",  bus.wrow,  32'h0);
        check("ack_next_wcol",  bus.wcol,  32'h0);
        check("ack_err_kept",   err_len,   32'h1);

        // data_load drop after word 12 of the tile
        for (int w = 1; w <= 12; w++) begin
            cycle(1'b1, 1'b0, pat(11, w), acc);
        end
        check("w12_wen",   bus.wen,   32'h1);
        check("w12_wbank", bus.wbank, 32'h2);
        check("w12_wrow",  bus.wrow,  32'h0);
        check("w12_wcol",  bus.wcol,  32'h2);
        data_load = 1'b0;
        cycle(1'b1, 1'b0, pat(11, 13), acc);
        check("drop_wen",     bus.wen,    32'h0);
        check("drop_rready",  bus.rready, 32'h0);
        check("drop_err_len", err_len,    32'h0);
        check("drop_hold_wcol", bus.wcol, 32'h2);
        cfg_cols  = 28'd5;
        data_load = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, acc);
        cycle(1'b1, 1'b0, pat(12, 0), acc);
        check("restart_wen",   bus.wen,   32'h1);
        check("restart_wbank", bus.wbank, 32'h0);
        check("restart_wrow",  bus.wrow,  32'h0);
        check("restart_wcol",  bus.wcol,  32'h0);
        check("restart_wdata", bus.wdata, pat(12, 0));

        // Reset mid-tile
        for (int w = 1; w <= 6; w++) begin
            cycle(1'b1, 1'b0, pat(12, w), acc);
        end
        check("pre_rst_wbank", bus.wbank, 32'h1);
        rst_n = 1'b0;
        cycle(1'b1, 1'b0, pat(12, 7), acc);
        check("mid_rst_rready",    bus.rready, 32'h0);
        check("mid_rst_wen",       bus.wen,    32'h0);
        check("mid_rst_wdata",     bus.wdata,  32'h0);
        check("mid_rst_wbank",     bus.wbank,  32'h0);
        check("mid_rst_wrow",      bus.wrow,   32'h0);
        check("mid_rst_wcol",      bus.wcol,   32'h0);
        check("mid_rst_tile_done", tile_done,  32'h0);
        check("mid_rst_err_len",   err_len,    32'h0);
        rst_n = 1'b1;
        bus.rvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
